wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard that drives the single write port of the register file. It merges single-cycle ALU results with long-latency multiply/divide (MDU) results arriving under a valid/ready handshake. Pending MDU results are buffered in a 2-entry queue. It tracks which destination registers have outstanding long-latency writes and flags read-after-write hazards to the decode stage. It sits between the execute stage and the register file write port (`w`, `W_Reg`, `W_Data`).

---
 rtl/wb_arbiter_pkg.sv | 18 +
 rtl/wb_fifo.sv | 58 +++++
 rtl/wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_wb_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter slice.
// Holds the machine word and register-address widths used across the core,
// the depth of the long-latency result buffer, and the encoding of the
// write-port source selected each cycle.
package wb_arbiter_pkg;

  localparam int WORD_LEN     = 32;
  localparam int REGADDR_LEN  = 5;
  localparam int WB_BUF_DEPTH = 2;

  // Which candidate owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_BUF  = 2'd2
  } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO that holds MDU results waiting for the write port.
// Ports:
//   clk, rst      clock (rising edge) and asynchronous active-low reset
//   push, din     write din at the tail (caller guarantees !full)
//   pop           drop the head (caller guarantees !empty)
//   full, empty   occupancy flags, derived from the registered count only
//   head          entry at the head of the queue
// Push and pop in the same cycle keep the count unchanged.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DW    = WORD_LEN + REGADDR_LEN,
  parameter int DEPTH = WB_BUF_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter and scoreboard for the register-file write port.
// Merges single-cycle ALU results with buffered MDU results, tracks
// destinations with outstanding long-latency writes and raises a
// read-after-write hazard for the decode stage.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   alu_valid/alu_dest/alu_data    ALU result (no backpressure)
//   alu_stall                      buffer full, ALU must stay idle
//   mdu_valid/mdu_ready            MDU result handshake
//   mdu_dest/mdu_data              MDU result payload
//   iss_valid/iss_dest             long-latency issue, marks dest pending
//   chk_reg1/chk_reg2, hazard      decode source check
//   w/W_Reg/W_Data                 registered register-file write port
//   err                            sticky protocol-violation flag
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int W  = WORD_LEN,
  parameter int AW = REGADDR_LEN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_dest,
  input  logic [W-1:0]  alu_data,
  output logic          alu_stall,
  input  logic          mdu_valid,
  output logic          mdu_ready,
  input  logic [AW-1:0] mdu_dest,
  input  logic [W-1:0]  mdu_data,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_dest,
  input  logic [AW-1:0] chk_reg1,
  input  logic [AW-1:0] chk_reg2,
  output logic          hazard,
  output logic          w,
  output logic [AW-1:0] W_Reg,
  output logic [W-1:0]  W_Data,
  output logic          err
);

  localparam int NREG = 1 << AW;
  localparam int EW   = AW + W;

  logic            full;
  logic            empty;
  logic [EW-1:0]   head;
  logic [AW-1:0]   head_dest;
  logic [W-1:0]    head_data;
  logic            push;
  logic            pop;
  wb_src_t         src;
  logic [AW-1:0]   sel_dest;
  logic [W-1:0]    sel_data;
  logic            wr_en;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic            err_nxt;

  wb_fifo #(.DW(EW), .DEPTH(WB_BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({mdu_dest, mdu_data}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign head_dest = head[EW-1:W];
  assign head_data = head[W-1:0];

  // Handshake depends only on occupancy, never on mdu_valid.
  assign mdu_ready = !full;
  assign alu_stall = full;
  assign push      = mdu_valid && !full;

  always_comb begin
    src = SRC_NONE;
    if (alu_valid)   src = SRC_ALU;
    else if (!empty) src = SRC_BUF;
  end

  assign pop = (src == SRC_BUF);

  always_comb begin
    sel_dest = '0;
    sel_data = '0;
    case (src)
      SRC_ALU: begin
        sel_dest = alu_dest;
        sel_data = alu_data;
      end
      SRC_BUF: begin
        sel_dest = head_dest;
        sel_data = head_data;
      end
      default: ;
    endcase
  end

  // Writes to $zero are consumed but never reach the register file.
  assign wr_en = (src != SRC_NONE) && (sel_dest != '0);

  // Clear before set so an issue to the same register in the same cycle wins.
  // Bit 0 is never set, which keeps $zero hazard-free.
  always_comb begin
    pending_nxt = pending;
    if (pop && head_dest != '0)         pending_nxt[head_dest] = 1'b0;
    if (iss_valid && iss_dest != '0)    pending_nxt[iss_dest]  = 1'b1;
  end

  assign hazard = pending[chk_reg1] | pending[chk_reg2];

  always_comb begin
    err_nxt = err;
    if (iss_valid && iss_dest != '0 && pending[iss_dest])  err_nxt = 1'b1;
    if (alu_valid && full)                                 err_nxt = 1'b1;
    if (pop && head_dest != '0 && !pending[head_dest])     err_nxt = 1'b1;
  end

  // Stage boundary: arbitration result -> register-file write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w       <= 1'b0;
      W_Reg   <= '0;
      W_Data  <= '0;
      err     <= 1'b0;
      pending <= '0;
    end else begin
      w       <= wr_en;
      err     <= err_nxt;
      pending <= pending_nxt;
      if (wr_en) begin
        W_Reg  <= sel_dest;
        W_Data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, ALU path, MDU path with hazard,
// buffer full/drain ordering, simultaneous push/pop and error flagging.
module tb_wb_arbiter;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid;
  logic [AW-1:0] alu_dest;
  logic [W-1:0]  alu_data;
  logic          alu_stall;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [AW-1:0] mdu_dest;
  logic [W-1:0]  mdu_data;
  logic          iss_valid;
  logic [AW-1:0] iss_dest;
  logic [AW-1:0] chk_reg1;
  logic [AW-1:0] chk_reg2;
  logic          hazard;
  logic          w;
  logic [AW-1:0] W_Reg;
  logic [W-1:0]  W_Data;
  logic          err;

  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter #(.W(W), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_dest  (alu_dest),
    .alu_data  (alu_data),
    .alu_stall (alu_stall),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_dest  (mdu_dest),
    .mdu_data  (mdu_data),
    .iss_valid (iss_valid),
    .iss_dest  (iss_dest),
    .chk_reg1  (chk_reg1),
    .chk_reg2  (chk_reg2),
    .hazard    (hazard),
    .w         (w),
    .W_Reg     (W_Reg),
    .W_Data    (W_Data),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
    mdu_valid = 1'b0; mdu_dest = '0; mdu_data = '0;
    iss_valid = 1'b0; iss_dest = '0;
  endtask

  task automatic issue(input logic [AW-1:0] d);
    idle();
    iss_valid = 1'b1; iss_dest = d;
    tick();
    iss_valid = 1'b0;
  endtask

  task automatic check_wr(input string tag, input logic [AW-1:0] r, input logic [W-1:0] d);
    check({tag, "_w"}, w, 1);
    check({tag, "_reg"}, W_Reg, r);
    check({tag, "_data"}, W_Data, d);
  endtask

  initial begin
    rst = 1'b0;
    chk_reg1 = '0; chk_reg2 = '0;
    idle();

    // Reset state
    tick(); tick();
    check("rst_w", w, 0);
    check("rst_wreg", W_Reg, 0);
    check("rst_wdata", W_Data, 0);
    check("rst_err", err, 0);
    check("rst_ready", mdu_ready, 1);
    check("rst_stall", alu_stall, 0);
    check("rst_hazard", hazard, 0);
    rst = 1'b1;
    tick();

    // ALU write, then $zero destination holds the port registers
    alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    check_wr("alu", 5'd5, 32'hDEADBEEF);
    alu_dest = 5'd0; alu_data = 32'h11111111;
    tick();
    check("alu0_w", w, 0);
    check("alu0_reg", W_Reg, 5);
    check("alu0_data", W_Data, 32'hDEADBEEF);
    idle();
    tick();
    check("idle_w", w, 0);

    // MDU write with hazard on r7
    chk_reg1 = 5'd7;
    iss_valid = 1'b1; iss_dest = 5'd7;
    #1 check("haz_issue", hazard, 0);
    tick();
    iss_valid = 1'b0;
    #1 check("haz_p1", hazard, 1);
    tick();
    check("haz_p2", hazard, 1);
    tick();
    mdu_valid = 1'b1; mdu_dest = 5'd7; mdu_data = 32'h1234;
    #1 check("mdu_ready", mdu_ready, 1);
    check("haz_accept", hazard, 1);
    tick();
    idle();
    #1 check("mdu_n1_w", w, 0);
    check("haz_n1", hazard, 1);
    tick();
    check_wr("mdu", 5'd7, 32'h1234);
    check("haz_clear", hazard, 0);
    check("mdu_err", err, 0);
    chk_reg1 = '0;

    // Buffer full under ALU priority, then FIFO-order drain
    issue(5'd10); issue(5'd11); issue(5'd12);
    alu_valid = 1'b1; alu_dest = 5'd1; alu_data = 32'hA1;
    mdu_valid = 1'b1; mdu_dest = 5'd10; mdu_data = 32'h100;
    #1 check("full_rdy0", mdu_ready, 1);
    tick();
    check_wr("full_alu1", 5'd1, 32'hA1);
    alu_dest = 5'd2; alu_data = 32'hA2;
    mdu_dest = 5'd11; mdu_data = 32'h101;
    #1 check("full_rdy1", mdu_ready, 1);
    tick();
    check_wr("full_alu2", 5'd2, 32'hA2);
    alu_valid = 1'b0;
    mdu_dest = 5'd12; mdu_data = 32'h102;
    #1 check("full_rdy2", mdu_ready, 0);
    check("full_stall", alu_stall, 1);
    tick();
    check_wr("drain0", 5'd10, 32'h100);
    // One entry left, no ALU: r12 accepted while r11 is written
    #1 check("pp_rdy", mdu_ready, 1);
    tick();
    mdu_valid = 1'b0;
    check_wr("drain1", 5'd11, 32'h101);
    check("pp_rdy_after", mdu_ready, 1);
    check("pp_stall_after", alu_stall, 0);
    tick();
    check_wr("drain2", 5'd12, 32'h102);
    check("drain_rdy", mdu_ready, 1);
    tick();
    check("drain_empty_w", w, 0);
    check("drain_err", err, 0);

    // WAW on r3 sets err, which stays set
    issue(5'd3);
    check("waw_pre_err", err, 0);
    issue(5'd3);
    check("waw_err", err, 1);
    tick();
    check("waw_sticky", err, 1);

    // Two entries buffered, then reset mid-stream
    chk_reg1 = 5'd3;
    alu_valid = 1'b1; alu_dest = 5'd4; alu_data = 32'h44;
    mdu_valid = 1'b1; mdu_dest = 5'd3; mdu_data = 32'h333;
    tick();
    mdu_data = 32'h334;
    tick();
    idle();
    #1 check("pre_rst_rdy", mdu_ready, 0);
    check("pre_rst_haz", hazard, 1);
    #2 rst = 1'b0;
    #1 check("mid_rst_w", w, 0);
    check("mid_rst_rdy", mdu_ready, 1);
    check("mid_rst_haz", hazard, 0);
    check("mid_rst_err", err, 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_w", w, 0);
    end
    check("post_rst_wreg", W_Reg, 0);

    // ALU while stalled: ALU wins, err set, buffer drains afterwards
    chk_reg1 = '0;
    issue(5'd20); issue(5'd21);
    alu_valid = 1'b1; alu_dest = 5'd1; alu_data = 32'hB1;
    mdu_valid = 1'b1; mdu_dest = 5'd20; mdu_data = 32'h200;
    tick();
    mdu_dest = 5'd21; mdu_data = 32'h201;
    tick();
    mdu_valid = 1'b0;
    alu_dest = 5'd6; alu_data = 32'h66;
    #1 check("stall_hi", alu_stall, 1);
    check("stall_err_pre", err, 0);
    tick();
    idle();
    check_wr("stall_alu", 5'd6, 32'h66);
    check("stall_err", err, 1);
    tick();
    check_wr("stall_drain0", 5'd20, 32'h200);
    tick();
    check_wr("stall_drain1", 5'd21, 32'h201);
    check("stall_err_sticky", err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
